// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one RV32I integer ALU between two valid/ready requesters.
// Results are registered and tagged with the requester index until the consumer accepts them.
module alu_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  localparam int unsigned SHW = 5;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(2);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(3);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
  localparam logic [OPW-1:0] OP_OR   = OPW'(8);
  localparam logic [OPW-1:0] OP_AND  = OPW'(9);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  logic            last_ptr;

  logic            can_accept_c;
  logic            grant_c;
  logic            accept_c;
  logic [OPW-1:0]  op_c;
  logic [XLEN-1:0] a_c;
  logic [XLEN-1:0] b_c;
  logic [SHW-1:0]  shamt_c;
  logic [XLEN-1:0] alu_data_c;
  logic            alu_err_c;

  // Drain-and-refill: a full register whose result is being taken can accept in the same cycle
  assign can_accept_c = (state == EMPTY) | (rsp_ready & (state == FULL));

  // Single requester wins outright; on contention the port not granted last time wins
  always_comb begin
    grant_c = ~last_ptr;
    if (req0_valid && !req1_valid) begin
      grant_c = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant_c = 1'b1;
    end
  end

  assign req0_ready = rst_n & can_accept_c & ~grant_c;
  assign req1_ready = rst_n & can_accept_c &  grant_c;
  assign accept_c   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign op_c    = grant_c ? req1_op : req0_op;
  assign a_c     = grant_c ? req1_a  : req0_a;
  assign b_c     = grant_c ? req1_b  : req0_b;
  assign shamt_c = b_c[SHW-1:0];

  always_comb begin
    alu_data_c = '0;
    alu_err_c  = 1'b0;
    case (op_c)
      OP_ADD:  alu_data_c = a_c + b_c;
      OP_SUB:  alu_data_c = a_c - b_c;
      OP_SLL:  alu_data_c = a_c << shamt_c;
      OP_SLT:  alu_data_c = XLEN'($signed(a_c) < $signed(b_c));
      OP_SLTU: alu_data_c = XLEN'(a_c < b_c);
      OP_XOR:  alu_data_c = a_c ^ b_c;
      OP_SRL:  alu_data_c = a_c >> shamt_c;
      OP_SRA:  alu_data_c = XLEN'($signed(a_c) >>> shamt_c);
      OP_OR:   alu_data_c = a_c | b_c;
      OP_AND:  alu_data_c = a_c & b_c;
      default: alu_err_c  = 1'b1;
    endcase
  end

  // Result register, occupancy FSM and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      last_ptr <= 1'b1;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept_c) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (rsp_ready && !accept_c) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (accept_c) begin
        last_ptr <= grant_c;
        rsp_id   <= grant_c;
        rsp_data <= alu_data_c;
        rsp_err  <= alu_err_c;
      end
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter: arbitration order, ALU results,
// backpressure hold, illegal opcodes and asynchronous reset while a result is held.
module tb_alu_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;

  logic            clk;
  logic            rst_n;
  logic            req0_valid;
  logic            req0_ready;
  logic [OPW-1:0]  req0_op;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [OPW-1:0]  req1_op;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            v0;
    logic [OPW-1:0]  op0;
    logic [XLEN-1:0] a0;
    logic [XLEN-1:0] b0;
    logic            v1;
    logic [OPW-1:0]  op1;
    logic [XLEN-1:0] a1;
    logic [XLEN-1:0] b1;
    logic            rr;
    logic            chk_rdy;
    logic            e_r0;
    logic            e_r1;
    logic            e_v;
    logic            chk_dat;
    logic            e_id;
    logic [XLEN-1:0] e_data;
    logic            e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic v0, input logic [OPW-1:0] op0, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] b0,
    input logic v1, input logic [OPW-1:0] op1, input logic [XLEN-1:0] a1, input logic [XLEN-1:0] b1,
    input logic rr, input logic chk_rdy, input logic e_r0, input logic e_r1,
    input logic e_v, input logic chk_dat, input logic e_id, input logic [XLEN-1:0] e_data,
    input logic e_err);
    vec_t t;
    t.v0 = v0; t.op0 = op0; t.a0 = a0; t.b0 = b0;
    t.v1 = v1; t.op1 = op1; t.a1 = a1; t.b1 = b1;
    t.rr = rr; t.chk_rdy = chk_rdy; t.e_r0 = e_r0; t.e_r1 = e_r1;
    t.e_v = e_v; t.chk_dat = chk_dat; t.e_id = e_id; t.e_data = e_data; t.e_err = e_err;
    return t;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, check readies just after, check the result just after the rising edge
  task automatic apply_vec(input vec_t t, input string tag);
    @(negedge clk);
    req0_valid = t.v0; req0_op = t.op0; req0_a = t.a0; req0_b = t.b0;
    req1_valid = t.v1; req1_op = t.op1; req1_a = t.a1; req1_b = t.b1;
    rsp_ready  = t.rr;
    #1;
    if (t.chk_rdy) begin
      check({tag, ".req0_ready"}, XLEN'(req0_ready), XLEN'(t.e_r0));
      check({tag, ".req1_ready"}, XLEN'(req1_ready), XLEN'(t.e_r1));
    end
    @(posedge clk);
    #1;
    check({tag, ".rsp_valid"}, XLEN'(rsp_valid), XLEN'(t.e_v));
    if (t.chk_dat) begin
      check({tag, ".rsp_id"},   XLEN'(rsp_id),  XLEN'(t.e_id));
      check({tag, ".rsp_data"}, rsp_data,       t.e_data);
      check({tag, ".rsp_err"},  XLEN'(rsp_err), XLEN'(t.e_err));
    end
  endtask

  localparam logic [OPW-1:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4;
  localparam logic [OPW-1:0] XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;
  localparam logic [OPW-1:0] ILL = 4'd12;

  vec_t vecs[12];

  initial begin
    // Pointer starts at 1, so contention grants alternate 1,0,1,... once port 0 has gone first
    vecs[0]  = mk(1, XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 0, ADD, 0, 0, 1, 1, 1, 0, 1, 1, 0, 32'hFF00FF00, 0);
    vecs[1]  = mk(1, ADD, 32'hFFFFFFFF, 32'h1, 1, SUB, 32'd5, 32'd7, 1, 1, 0, 1, 1, 1, 1, 32'hFFFFFFFE, 0);
    vecs[2]  = mk(1, ADD, 32'hFFFFFFFF, 32'h1, 1, SUB, 32'd5, 32'd7, 1, 1, 1, 0, 1, 1, 0, 32'h00000000, 0);
    vecs[3]  = mk(1, SRA, 32'h80000000, 32'h24, 1, SRL, 32'h80000000, 32'h24, 1, 1, 0, 1, 1, 1, 1, 32'h08000000, 0);
    vecs[4]  = mk(1, SRA, 32'h80000000, 32'h24, 1, SLT, 32'hFFFFFFFF, 32'h1, 1, 1, 1, 0, 1, 1, 0, 32'hF8000000, 0);
    vecs[5]  = mk(1, SLTU, 32'hFFFFFFFF, 32'h1, 1, SLT, 32'hFFFFFFFF, 32'h1, 1, 1, 0, 1, 1, 1, 1, 32'h00000001, 0);
    vecs[6]  = mk(1, SLTU, 32'hFFFFFFFF, 32'h1, 0, ADD, 0, 0, 1, 1, 1, 0, 1, 1, 0, 32'h00000000, 0);
    vecs[7]  = mk(0, ADD, 0, 0, 1, ILL, 32'h1234, 32'h5678, 1, 1, 0, 1, 1, 1, 1, 32'h00000000, 1);
    vecs[8]  = mk(0, ADD, 0, 0, 1, AND, 32'hFFFF0000, 32'h0F0F0F0F, 1, 1, 0, 1, 1, 1, 1, 32'h0F0F0000, 0);
    vecs[9]  = mk(1, OR, 32'h000000F0, 32'h00000F00, 0, ADD, 0, 0, 1, 1, 1, 0, 1, 1, 0, 32'h00000FF0, 0);
    vecs[10] = mk(1, SLL, 32'h00000001, 32'h21, 0, ADD, 0, 0, 1, 1, 1, 0, 1, 1, 0, 32'h00000002, 0);
    vecs[11] = mk(0, ADD, 0, 0, 0, ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);

    // Reset with both requesters asserting valid
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = ADD; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = ADD; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req0_ready", XLEN'(req0_ready), 32'h0);
    check("rst.req1_ready", XLEN'(req1_ready), 32'h0);
    check("rst.rsp_valid",  XLEN'(rsp_valid),  32'h0);
    check("rst.rsp_data",   rsp_data,          32'h0);
    check("rst.rsp_id",     XLEN'(rsp_id),     32'h0);
    check("rst.rsp_err",    XLEN'(rsp_err),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    for (int i = 0; i < 12; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: first result held for 5 cycles, then same-cycle drain and refill
    apply_vec(mk(1, ADD, 32'd10, 32'd20, 0, ADD, 0, 0, 1, 1, 1, 0, 1, 1, 0, 32'd30, 0), "bp.first");
    for (int i = 0; i < 5; i++) begin
      apply_vec(mk(1, ADD, 32'd1, 32'd2, 1, SUB, 32'd100, 32'd1, 0, 1, 0, 0, 1, 1, 0, 32'd30, 0),
                $sformatf("bp.hold%0d", i));
    end
    apply_vec(mk(1, ADD, 32'd1, 32'd2, 1, SUB, 32'd100, 32'd1, 1, 1, 0, 1, 1, 1, 1, 32'd99, 0), "bp.refill1");
    apply_vec(mk(1, ADD, 32'd1, 32'd2, 0, ADD, 0, 0, 1, 1, 1, 0, 1, 1, 0, 32'd3, 0), "bp.refill0");

    // Asynchronous reset while a result is held
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.rsp_valid",  XLEN'(rsp_valid),  32'h0);
    check("arst.req0_ready", XLEN'(req0_ready), 32'h0);
    check("arst.req1_ready", XLEN'(req1_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec(mk(0, ADD, 0, 0, 0, ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0), "arst.idle");
    apply_vec(mk(1, ADD, 32'd1, 32'd1, 1, ADD, 32'd2, 32'd2, 1, 1, 1, 0, 1, 1, 0, 32'd2, 0), "arst.prio");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares a single RV32I integer ALU datapath (ADD/SUB/shifts/compares/XOR/OR/AND) between two requesters: port 0 is the execute stage and port 1 is the address/branch unit. Each requester uses a valid/ready handshake. The block grants round-robin, computes in one cycle and holds a registered, tagged result until the consumer accepts it. It sits between the issue logic and the shared ALU and replaces per-unit ALU copies.

Parameters:
XLEN, 32, operand/result width (only 32 supported by tests)
OPW, 4, operation code width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  OPW  requester 0 operation code
req0_a  in  XLEN  requester 0 operand a
req0_b  in  XLEN  requester 0 operand b
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as port 0, for requester 1
rsp_valid  out  1  result register holds a valid result
rsp_ready  in  1  consumer takes result this cycle
rsp_id  out  1  index of requester that produced the result
rsp_data  out  XLEN  result
rsp_err  out  1  operation code was unsupported

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, last-grant pointer=1 (port 0 has first priority), FSM=EMPTY. req*_ready=0 while in reset.
- FSM states:
  - EMPTY: result register free.
  - FULL: result held, waiting for rsp_ready.
- can_accept = (state==EMPTY) | (rsp_ready & state==FULL). Accept with a full register and rsp_ready high is a same-cycle drain-and-refill, so 1 result per cycle is sustained.
- Arbitration: combinational, evaluated only when can_accept.
  - Only one valid: that port is granted.
  - Both valid: the port other than the last-grant pointer is granted.
  - Pointer updates to the granted port on accept only.
  - reqX_ready = can_accept & granted port==X. At most one ready is high per cycle.
  - reqX_ready does not depend on reqY_ready.
- Accept on edge with reqX_valid & reqX_ready:
  - rsp_data, rsp_err and rsp_id=X are registered.
  - state goes to FULL.
  - Latency from accept edge to rsp_valid=1 is 1 cycle.
- rsp_valid=1 & rsp_ready=1 with no new accept: state goes to EMPTY and rsp_valid=0 next cycle. rsp_data keeps its old value (don't-care).
- While FULL and rsp_ready=0: rsp_* outputs stable; both readies 0.
- Requesters must hold op/a/b stable while valid & !ready. The arbiter may switch grant only after an accept.
- Op encoding (all 32-bit, wrap modulo 2^32, shift amount = b[4:0]):
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 SLL
  - 3 SLT signed a<b → 1/0
  - 4 SLTU unsigned
  - 5 XOR a^b
  - 6 SRL logical
  - 7 SRA arithmetic
  - 8 OR
  - 9 AND
  - 10–15: result 0, rsp_err=1. The error result is still handshaked normally.
- Reset mid-operation: the held result is dropped immediately. No rsp_valid after release until a new accept.
- No combinational path from rsp_ready to rsp_valid/rsp_data.

Test Plan:
- Reset then idle: rst_n=0 with both valid=1 → readies 0, rsp_valid 0. Release; req0 XOR a=0xF0F0F0F0 b=0x0FF00FF0 → next cycle rsp_valid=1, rsp_id=0, rsp_data=0xFF00FF00, rsp_err=0.
- Round-robin under contention: both valid continuously, rsp_ready=1.
  - Grants alternate 0,1,0,1.
  - req0 ADD 0xFFFFFFFF+1 → 0x00000000 (wrap).
  - req1 SUB 5-7 → 0xFFFFFFFE.
  - One result per cycle, no gaps.
- Backpressure: rsp_ready=0 after first accept → rsp_data held for 5 cycles, req0_ready=req1_ready=0. Raise rsp_ready → same-cycle refill, next result appears the following cycle.
- Shifts/compares:
  - SRA 0x80000000 by b=0x24 (amount 4) → 0xF8000000.
  - SRL same → 0x08000000.
  - SLT 0xFFFFFFFF<1 → 1.
  - SLTU same → 0.
- Illegal op 12 on req1 → rsp_data=0, rsp_err=1, rsp_id=1. The next legal op has rsp_err=0.
- Async reset while FULL: assert rst_n mid-cycle → rsp_valid drops before the next clock edge. After release, pointer restores port-0 priority on simultaneous requests.
